// File: rtl/vector_pkg.sv
// ---------------------------------------------------------------------------
// vector_pkg
// Shared definitions for the vector sequencer: operation encodings and the
// sequencer FSM state enumeration. Imported by vector_seq_unit and vrf_param.
// ---------------------------------------------------------------------------
package vector_pkg;

  localparam logic [1:0] VOP_LOAD  = 2'b00;
  localparam logic [1:0] VOP_STORE = 2'b01;
  localparam logic [1:0] VOP_ADD   = 2'b10;
  localparam logic [1:0] VOP_SUB   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPRD  = 3'd1,
    LOAD  = 3'd2,
    CAP   = 3'd3,
    STORE = 3'd4,
    EXEC  = 3'd5,
    WB    = 3'd6,
    DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/vrf_param.sv
// ---------------------------------------------------------------------------
// vrf_param
// Vector register file: NVREG registers of LANES*EW bits each.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low clear of all regs
//   i_ra_sel / o_ra_data     combinational read port A
//   i_rb_sel / o_rb_data     combinational read port B
//   i_dbg_sel / o_dbg_data   combinational debug read port
//   i_we, i_wsel, i_wdata    synchronous write port
// ---------------------------------------------------------------------------
module vrf_param
  import vector_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int NVREG = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [$clog2(NVREG)-1:0]   i_ra_sel,
  output logic [LANES*EW-1:0]        o_ra_data,
  input  logic [$clog2(NVREG)-1:0]   i_rb_sel,
  output logic [LANES*EW-1:0]        o_rb_data,
  input  logic [$clog2(NVREG)-1:0]   i_dbg_sel,
  output logic [LANES*EW-1:0]        o_dbg_data,
  input  logic                       i_we,
  input  logic [$clog2(NVREG)-1:0]   i_wsel,
  input  logic [LANES*EW-1:0]        i_wdata
);

  logic [LANES*EW-1:0] r_regs [NVREG];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NVREG; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      r_regs[i_wsel] <= i_wdata;
    end
  end

  assign o_ra_data  = r_regs[i_ra_sel];
  assign o_rb_data  = r_regs[i_rb_sel];
  assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/vector_seq_unit.sv
// ---------------------------------------------------------------------------
// vector_seq_unit
// Multi-cycle vector sequencer: VLOAD/VSTORE move one lane per cycle between
// a synchronous data memory and the register file; VADD/VSUB operate on all
// lanes in one EXEC cycle. Lane 0 is the most significant lane of a vector.
// Ports:
//   clock, reset (async, active-low)
//   start, op, vd, vs, base_addr      operation request (sampled in IDLE)
//   busy, done                        status / one-cycle completion pulse
//   mem_addr, mem_rd, mem_wr,
//   mem_wdata, mem_rdata              synchronous memory (rdata one cycle late)
//   dbg_sel, dbg_vec                  combinational register read-out
// Build option: define VECTOR_SAT_EN for unsigned saturating VADD/VSUB;
// otherwise lanes wrap modulo 2^EW.
// ---------------------------------------------------------------------------
module vector_seq_unit
  import vector_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EW    = 8,
  parameter int AW    = 8,
  parameter int NVREG = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [1:0]                 op,
  input  logic [$clog2(NVREG)-1:0]   vd,
  input  logic [$clog2(NVREG)-1:0]   vs,
  input  logic [AW-1:0]              base_addr,
  output logic                       busy,
  output logic                       done,
  output logic [AW-1:0]              mem_addr,
  output logic                       mem_rd,
  output logic                       mem_wr,
  output logic [EW-1:0]              mem_wdata,
  input  logic [EW-1:0]              mem_rdata,
  input  logic [$clog2(NVREG)-1:0]   dbg_sel,
  output logic [LANES*EW-1:0]        dbg_vec
);

  localparam int RW = $clog2(NVREG);
  localparam int KW = $clog2(LANES);
  localparam int VW = LANES * EW;
  localparam logic [KW-1:0] K_LAST = KW'(LANES - 1);

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_op;
  logic [RW-1:0]   r_vd, r_vs;
  logic [AW-1:0]   r_base;
  logic [KW-1:0]   r_k;
  logic [VW-1:0]   r_x1, r_x2, r_t;

  logic [VW-1:0]   w_vec_a, w_vec_b;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  logic [EW-1:0]   w_x1_lane;

  function automatic logic [EW-1:0] lane_op(input logic [EW-1:0] a,
                                            input logic [EW-1:0] b,
                                            input logic          sub);
`ifdef VECTOR_SAT_EN
    logic [EW:0] s;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b};
      return s[EW] ? '0 : s[EW-1:0];   // borrow out means a < b: clamp at 0
    end else begin
      s = {1'b0, a} + {1'b0, b};
      return s[EW] ? '1 : s[EW-1:0];   // carry out: clamp at all-ones
    end
`else
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  // Lane-by-lane evaluation: no carry crosses lane borders.
  function automatic logic [VW-1:0] vec_op(input logic [VW-1:0] a,
                                           input logic [VW-1:0] b,
                                           input logic          sub);
    logic [VW-1:0] res;
    res = '0;
    for (int i = 0; i < LANES; i++)
      res[i*EW +: EW] = lane_op(a[i*EW +: EW], b[i*EW +: EW], sub);
    return res;
  endfunction

  vrf_param #(
    .LANES (LANES),
    .EW    (EW),
    .NVREG (NVREG)
  ) u_vrf (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_ra_sel   (r_vd),
    .o_ra_data  (w_vec_a),
    .i_rb_sel   (r_vs),
    .o_rb_data  (w_vec_b),
    .i_dbg_sel  (dbg_sel),
    .o_dbg_data (dbg_vec),
    .i_we       (w_we),
    .i_wsel     (r_vd),
    .i_wdata    (r_t)
  );

  assign w_we      = (r_state == WB);
  assign w_addr    = r_base + AW'(r_k);   // wraps modulo 2^AW
  assign w_x1_lane = r_x1[(LANES - 1 - int'(r_k))*EW +: EW];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op   <= '0;
      r_vd   <= '0;
      r_vs   <= '0;
      r_base <= '0;
      r_k    <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_t    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op   <= op;
            r_vd   <= vd;
            r_vs   <= vs;
            r_base <= base_addr;
            r_k    <= '0;
          end
        end
        OPRD: begin
          r_x1 <= w_vec_a;
          r_x2 <= w_vec_b;
        end
        LOAD: begin
          // Memory answers one cycle late: in step k the data for lane k-1 arrives.
          if (r_k != '0) r_t[(LANES - int'(r_k))*EW +: EW] <= mem_rdata;
          r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        end
        CAP:   r_t[EW-1:0] <= mem_rdata;
        STORE: r_k <= (r_k == K_LAST) ? '0 : r_k + 1'b1;
        EXEC:  r_t <= vec_op(r_x1, r_x2, (r_op == VOP_SUB));
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = (op == VOP_LOAD) ? LOAD : OPRD;
      end
      OPRD: w_state_nxt = (r_op == VOP_STORE) ? STORE : EXEC;
      LOAD: begin
        mem_rd   = 1'b1;
        mem_addr = w_addr;
        if (r_k == K_LAST) w_state_nxt = CAP;
      end
      CAP:  w_state_nxt = WB;
      STORE: begin
        mem_wr    = 1'b1;
        mem_addr  = w_addr;
        mem_wdata = w_x1_lane;
        if (r_k == K_LAST) w_state_nxt = DONE;
      end
      EXEC: w_state_nxt = WB;
      WB:   w_state_nxt = DONE;
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
